// File: rtl/ram_io_responder.sv
// ram_io_responder
//
// Byte-wide responder at the far end of the memory controller's RAM port.
// Single-byte reads and writes go to a local byte RAM, except for a small
// 8-byte IO window at IO_ADDR:
//   IO_ADDR+0 : write pushes a console byte into the TX FIFO,
//               read pops the head of the RX FIFO (0x00 when empty)
//   IO_ADDR+4 : write sets the sticky halt flag,
//               read returns {6'b0, rx_not_empty, tx_full}
//   others    : reads return 0x00, writes are ignored
// Read data is registered, so a read always returns data one edge after the
// address is presented.
//
// Ports:
//   clk_in        single clock, rising edge
//   rst_in        asynchronous active-high reset
//   wr_in         1 = write this cycle, 0 = read
//   addr_in       32-bit byte address
//   data_in       write data
//   data_out      registered read data, held across write cycles
//   tx_data       combinational head of the TX FIFO
//   tx_valid      TX FIFO not empty
//   tx_ready      sink accepts tx_data this cycle
//   rx_data       incoming console byte
//   rx_valid      push rx_data into the RX FIFO
//   io_full       TX FIFO full
//   overflow_out  sticky, a TX or RX byte was dropped
//   halt_out      sticky, the program requested a halt

module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] IO_ADDR    = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_in,
  input  logic [31:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        io_full,
  output logic        overflow_out,
  output logic        halt_out
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Storage (no reset: RAM contents survive reset, FIFO slots are only
  // meaningful between the pointers)
  logic [7:0] ram_mem [0:RAM_DEPTH-1];
  logic [7:0] tx_mem  [0:FIFO_DEPTH-1];
  logic [7:0] rx_mem  [0:FIFO_DEPTH-1];

  // Registered state
  logic [7:0]       data_q,      data_d;
  logic             halt_q,      halt_d;
  logic             overflow_q,  overflow_d;
  logic             run_q,       run_d;
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0] tx_cnt_q,    tx_cnt_d;
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PTR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CNT_W-1:0] rx_cnt_q,    rx_cnt_d;

  // Decode and handshake terms
  logic [31:0]           io_offset;
  logic                  in_window;
  logic                  sel_txrx;
  logic                  sel_stat;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  tx_empty, tx_full, rx_empty, rx_full;
  logic                  tx_pop, tx_push_req, tx_push;
  logic                  rx_pop, rx_push;

  // The offset from the window base drives the whole decode. Anything that
  // falls outside the 8-byte window is RAM, with upper address bits aliased.
  always_comb begin
    io_offset = addr_in - IO_ADDR;
    in_window = io_offset < 32'd8;
    sel_txrx  = io_offset == 32'd0;
    sel_stat  = io_offset == 32'd4;
    ram_idx   = addr_in[ADDR_WIDTH-1:0];
    ram_we    = wr_in && !in_window;
  end

  // FIFO handshakes. Full/empty come from the registered counts, so status
  // and io_full describe the state at the start of the cycle. A push into a
  // full FIFO still succeeds when the same cycle pops, because the pop frees
  // the slot the write pointer is sitting on.
  always_comb begin
    tx_empty    = tx_cnt_q == '0;
    tx_full     = tx_cnt_q == FULL_CNT;
    rx_empty    = rx_cnt_q == '0;
    rx_full     = rx_cnt_q == FULL_CNT;

    tx_pop      = !tx_empty && tx_ready;
    // Only the first cycle of a run of IO stores pushes; the controller may
    // hold the address and write strobe for several cycles per store.
    tx_push_req = wr_in && sel_txrx && !run_q;
    tx_push     = tx_push_req && (!tx_full || tx_pop);

    rx_pop      = !wr_in && sel_txrx && !rx_empty;
    rx_push     = rx_valid && (!rx_full || rx_pop);
  end

  // Next-state for the FIFO pointers and occupancy counts. Pointers are
  // log2(depth) wide so they wrap on their own.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);

    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
  end

  // Sticky flags and the IO-store run tracker. Any cycle that is not an
  // IO_ADDR write ends the current run.
  always_comb begin
    run_d      = wr_in && sel_txrx;
    halt_d     = halt_q || (wr_in && sel_stat);
    overflow_d = overflow_q
               || (tx_push_req && !tx_push)
               || (rx_valid && !rx_push);
  end

  // Read data mux. Writes leave the previous read value in place. The RAM is
  // read asynchronously here and registered below, which makes a read in the
  // cycle right after a write see the new byte.
  always_comb begin
    data_d = data_q;
    if (!wr_in) begin
      if (sel_txrx) begin
        data_d = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
      end else if (sel_stat) begin
        data_d = {6'b0, !rx_empty, tx_full};
      end else if (in_window) begin
        data_d = 8'h00;
      end else begin
        data_d = ram_mem[ram_idx];
      end
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q      <= '0;
      halt_q      <= 1'b0;
      overflow_q  <= 1'b0;
      run_q       <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      data_q      <= data_d;
      halt_q      <= halt_d;
      overflow_q  <= overflow_d;
      run_q       <= run_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // Storage writes
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram_mem[ram_idx]     <= data_in;
    if (tx_push) tx_mem[tx_wr_ptr_q]  <= data_in;
    if (rx_push) rx_mem[rx_wr_ptr_q]  <= rx_data;
  end

  // tx_data is forced to zero while empty so that reset, which empties the
  // FIFO, also clears it without resetting the storage.
  always_comb begin
    data_out     = data_q;
    tx_valid     = !tx_empty;
    tx_data      = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_q];
    io_full      = tx_full;
    overflow_out = overflow_q;
    halt_out     = halt_q;
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder
//
// Directed bench for ram_io_responder. A behavioural model (byte map for the
// RAM, queues for the two FIFOs, sticky flags) predicts every output; read
// expectations are queued when the read is driven and popped when data_out
// is sampled one edge later.

module tb_ram_io_responder;

  localparam logic [31:0] IO    = 32'h30000;
  localparam int          DEPTH = 8;

  logic        clk_in;
  logic        rst_in;
  logic        wr_in;
  logic [31:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        io_full;
  logic        overflow_out;
  logic        halt_out;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  logic [7:0] ramModel [int];
  logic [7:0] txModel [$];
  logic [7:0] rxModel [$];
  logic [7:0] scoreboard [$];
  logic [7:0] doutModel;
  bit         runModel;
  bit         ovfModel;
  bit         haltModel;

  ram_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_in        (wr_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .io_full      (io_full),
    .overflow_out (overflow_out),
    .halt_out     (halt_out)
  );

  // 10-unit clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // Drive one bus cycle, advance past the edge, step the model and compare.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [7:0] data, input logic rdy,
                               input logic rxv, input logic [7:0] rxd);
    logic [31:0] off;
    bit          isIo, isStat, inWin;
    bit          txPop, txReq, txFull, rxPop, rxFull;
    logic [7:0]  expRead;
    int          idx;

    off    = addr - IO;
    isIo   = (off == 32'd0);
    isStat = (off == 32'd4);
    inWin  = (off < 32'd8);
    idx    = int'(addr[16:0]);

    if (!wr) begin
      if (isIo)        expRead = (rxModel.size() != 0) ? rxModel[0] : 8'h00;
      else if (isStat) expRead = {6'b0, rxModel.size() != 0, txModel.size() == DEPTH};
      else if (inWin)  expRead = 8'h00;
      else             expRead = ramModel.exists(idx) ? ramModel[idx] : 8'h00;
      scoreboard.push_back(expRead);
    end

    txFull = (txModel.size() == DEPTH);
    txPop  = (txModel.size() != 0) && rdy;
    txReq  = wr && isIo && !runModel;
    rxFull = (rxModel.size() == DEPTH);
    rxPop  = !wr && isIo && (rxModel.size() != 0);

    wr_in    = wr;
    addr_in  = addr;
    data_in  = data;
    tx_ready = rdy;
    rx_valid = rxv;
    rx_data  = rxd;
    @(posedge clk_in);
    #1;

    if (txPop) void'(txModel.pop_front());
    if (txReq) begin
      if (!txFull || txPop) txModel.push_back(data);
      else                  ovfModel = 1'b1;
    end
    if (rxPop) void'(rxModel.pop_front());
    if (rxv) begin
      if (!rxFull || rxPop) rxModel.push_back(rxd);
      else                  ovfModel = 1'b1;
    end
    runModel = wr && isIo;
    if (wr && isStat) haltModel = 1'b1;
    if (wr && !inWin) ramModel[idx] = data;

    if (!wr) doutModel = scoreboard.pop_front();
    checkOutput(wr ? "data_out_hold" : "data_out_read", data_out, doutModel);
    checkOutput("tx_valid", {7'b0, tx_valid}, {7'b0, txModel.size() != 0});
    if (txModel.size() != 0) checkOutput("tx_data", tx_data, txModel[0]);
    checkOutput("io_full", {7'b0, io_full}, {7'b0, txModel.size() == DEPTH});
    checkOutput("overflow_out", {7'b0, overflow_out}, {7'b0, ovfModel});
    checkOutput("halt_out", {7'b0, halt_out}, {7'b0, haltModel});
  endtask

  task automatic ramWrite(input logic [31:0] addr, input logic [7:0] d);
    applyStimulus(1'b1, addr, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic readAddr(input logic [31:0] addr);
    applyStimulus(1'b0, addr, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic ioWrite(input logic [7:0] d, input logic rdy);
    applyStimulus(1'b1, IO, d, rdy, 1'b0, 8'h00);
  endtask

  // Idle cycle: a read of an unused window byte, which also ends a store run
  task automatic idleCycle(input logic rdy, input logic rxv, input logic [7:0] rxd);
    applyStimulus(1'b0, IO + 32'd1, 8'h00, rdy, rxv, rxd);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, data_out, 8'h00);
    checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
    checkOutput({tag, "_tx_valid"}, {7'b0, tx_valid}, 8'h00);
    checkOutput({tag, "_io_full"}, {7'b0, io_full}, 8'h00);
    checkOutput({tag, "_overflow"}, {7'b0, overflow_out}, 8'h00);
    checkOutput({tag, "_halt"}, {7'b0, halt_out}, 8'h00);
  endtask

  initial begin
    rst_in   = 1'b1;
    wr_in    = 1'b0;
    addr_in  = IO + 32'd1;
    data_in  = 8'h00;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    doutModel = 8'h00;
    runModel  = 1'b0;
    ovfModel  = 1'b0;
    haltModel = 1'b0;

    @(posedge clk_in);
    #1;
    checkAllZero("reset");
    rst_in = 1'b0;

    // RAM round trip, alias, write-then-read, pad write ignored
    ramWrite(32'h00010, 8'hA5);
    readAddr(32'h00010);
    readAddr(32'h20010);
    ramWrite(32'h00011, 8'h5A);
    readAddr(32'h00011);
    ramWrite(32'h10005, 8'h11);
    applyStimulus(1'b1, IO + 32'd5, 8'hEE, 1'b0, 1'b0, 8'h00);
    readAddr(32'h10005);
    readAddr(IO + 32'd7);

    // IO store held for five cycles yields a single TX entry
    for (int i = 0; i < 5; i++) ioWrite(8'h41, 1'b0);
    idleCycle(1'b1, 1'b0, 8'h00);

    // Fill TX, then push and pop together while full
    for (int i = 1; i <= DEPTH; i++) begin
      ioWrite(8'(i), 1'b0);
      idleCycle(1'b0, 1'b0, 8'h00);
    end
    readAddr(IO + 32'd4);
    ioWrite(8'h99, 1'b1);
    idleCycle(1'b0, 1'b0, 8'h00);

    // Ninth byte into a full FIFO is dropped
    ioWrite(8'h9A, 1'b0);
    idleCycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) idleCycle(1'b1, 1'b0, 8'h00);

    // RX path
    idleCycle(1'b0, 1'b1, 8'h31);
    idleCycle(1'b0, 1'b1, 8'h32);
    readAddr(IO);
    readAddr(IO);
    readAddr(IO);
    readAddr(IO + 32'd4);

    // RX empty with simultaneous push and read: no bypass
    applyStimulus(1'b0, IO, 8'h00, 1'b0, 1'b1, 8'h33);
    readAddr(IO + 32'd4);
    readAddr(IO);

    // RX full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) idleCycle(1'b0, 1'b1, 8'(8'h50 + i));
    applyStimulus(1'b0, IO, 8'h00, 1'b0, 1'b1, 8'h58);
    for (int i = 0; i < DEPTH + 1; i++) readAddr(IO);

    // Halt, then reset in the middle of an IO store run
    applyStimulus(1'b1, IO + 32'd4, 8'hFF, 1'b0, 1'b0, 8'h00);
    ioWrite(8'h77, 1'b0);
    #2 rst_in = 1'b1;
    #1 checkAllZero("midreset");
    txModel.delete();
    rxModel.delete();
    scoreboard.delete();
    doutModel = 8'h00;
    runModel  = 1'b0;
    ovfModel  = 1'b0;
    haltModel = 1'b0;
    #1 rst_in = 1'b0;

    // First IO store after reset counts as a new run; RAM survives reset
    ioWrite(8'h78, 1'b0);
    readAddr(32'h00010);
    readAddr(32'h00011);
    idleCycle(1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
